data_ex_unit: RTL and testbench
===============================

# data_ex_unit

Execute-stage datapath of the 5-stage pipelined 64-bit CPU. Selects forwarded ALU operands and computes the ALU result with combinational flags. Holds the architectural condition flags (N, Z, V, C) in registers updated only on flag-setting instructions. Also computes the PC-relative branch target, PC + (offset << 2).

## Interface
- No parameters.
- clk  in  1  single system clock; flag registers capture on rising edge
- reset  in  1  asynchronous, active-low; clears flag registers while low
- ReadData1  in  64  register-file operand A
- ReadData2  in  64  register-file operand B
- PC  in  64  PC of the instruction in EX
- ALU_or_DT  in  64  sign/zero-extended immediate or D-type offset
- BR_to_shift  in  64  sign-extended branch offset, in words
- alu_result_mem  in  64  forwarded ALU result from the MEM stage
- alu_result_wb  in  64  forwarded result from the WB stage
- ALUop  in  3  ALU operation select
- forwardA  in  2  operand-A forward select
- forwardB  in  2  operand-B forward select
- ALUsrc  in  1  1 = immediate (ALU_or_DT), 0 = ReadData2
- update  in  1  1 = latch ALU flags at this edge (flag-setting instruction)
- cbz_id  in  1  1 = CBZ in flight; zero output bypasses the flag register
- alu_result  out  64  combinational ALU result
- new_PC2  out  64  combinational branch target
- negative, overflow, carry_out  out  1 each  registered flags
- zero  out  1  zero flag, registered or bypassed (see Operation)

## Operation
- B pre-select: add2 = ALUsrc ? ALU_or_DT : ReadData2.
- Operand A select by forwardA:
  - 00 → ReadData1
  - 01 → alu_result_mem
  - 10 → alu_result_wb
  - 11 → ReadData1
- Operand B select by forwardB:
  - 00 → add2
  - 01 → alu_result_mem
  - 10 → alu_result_wb
  - 11 → add2
  - A nonzero forwardB overrides the immediate; hazard logic is responsible for this.
- ALU operations by ALUop:
  - 000 → B (pass-through)
  - 010 → A+B
  - 011 → A−B, computed as A + ~B + 1
  - 100 → A&B
  - 101 → A|B
  - 110 → A^B
  - 001 and 111 → result 0
- Combinational flags, all ops:
  - N = result[63]
  - Z = (result == 0)
- Combinational flags, add/sub:
  - C = carry out of bit 63; for subtract, C = 1 means no borrow.
  - V = signed overflow: carry-in(63) XOR carry-out(63).
- Combinational flags, other ops: C = 0, V = 0.
- All arithmetic is modulo 2^64.
- Flag registers (nq, zq, vq, cq):
  - Next value = update ? combinational flag : current value.
  - negative = nq, overflow = vq, carry_out = cq.
- zero output = cbz_id ? combinational Z : zq.
  - Z is the live ALU zero; CBZ passes the operand through with op 000.
  - The zero output must not feed back into the flag-register next-state logic, so there is no combinational loop.
- Branch target: new_PC2 = PC + (BR_to_shift << 2).
  - Logical left shift; upper 2 bits discarded.
  - Sum modulo 2^64.

## Timing
- alu_result, new_PC2 and the zero output (when cbz_id = 1) are purely combinational, 0-cycle latency.
- Flags latch at the rising clk edge when update = 1; the new values are visible on the outputs right after that edge.
- update = 0: flags hold indefinitely.
- reset low:
  - nq, zq, vq, cq = 0 immediately, independent of clk.
  - negative = overflow = carry_out = 0.
  - zero = 0 unless cbz_id = 1.
- Release of reset: flags hold 0 until the first edge with update = 1.
- Reset asserted mid-sequence clears flags regardless of update.
- update = 1 and cbz_id = 1 together: zero output shows live Z; zq also captures Z at the edge.
- No handshake and no state machine beyond the four flag registers.

## Test plan
- Add via register operand:
  - Stimulus: RD1 = 0x2AA, RD2 = 0x155, ALUsrc = 0, ALUop = 010, forward = 00, BR_to_shift = 2, PC = 0, update = 0.
  - Response: alu_result = 0x3FF; new_PC2 = 0x8; flags stay 0 after edges.
- Add via immediate with flag update:
  - Stimulus: ALU_or_DT = 1, ALUsrc = 1, update = 1, BR_to_shift = 0x80.
  - Response: alu_result = 0x2AB; new_PC2 = 0x200; after the edge N = Z = V = C = 0.
- Negative result without update:
  - Stimulus: RD1 = 0xFFFF_FFFF_FFFF_FAAA, immediate 1, update = 0.
  - Response: alu_result = 0xFFFF_FFFF_FFFF_FAAB; negative stays 0.
  - Then pulse update = 1: negative = 1 after the edge.
- Subtract and overflow:
  - 5 − 5 with update = 1 → result 0; Z = 1, C = 1, N = 0, V = 0.
  - 0x7FFF_FFFF_FFFF_FFFF + 1 with update = 1 → V = 1, N = 1, C = 0.
- Forwarding:
  - forwardA = 01 with alu_result_mem = 10, forwardB = 10 with alu_result_wb = 3, op 011 → alu_result = 7.
  - forwardB = 11 falls back to add2.
- CBZ bypass and reset:
  - Set zq = 0, then cbz_id = 1, ALUop = 000, B = 0 → zero = 1 immediately.
  - Drop reset low asynchronously mid-cycle → all registered flags read 0 before the next edge.

Source files
------------

// File: rtl/data_ex_unit.sv
// Execute-stage datapath: forwarded operand select, 64-bit ALU with N/Z/V/C flags,
// architectural flag registers and PC-relative branch target.
module data_ex_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] ReadData1,
    input  logic [63:0] ReadData2,
    input  logic [63:0] PC,
    input  logic [63:0] ALU_or_DT,
    input  logic [63:0] BR_to_shift,
    input  logic [63:0] alu_result_mem,
    input  logic [63:0] alu_result_wb,
    input  logic [2:0]  ALUop,
    input  logic [1:0]  forwardA,
    input  logic [1:0]  forwardB,
    input  logic        ALUsrc,
    input  logic        update,
    input  logic        cbz_id,
    output logic [63:0] alu_result,
    output logic [63:0] new_PC2,
    output logic        negative,
    output logic        zero,
    output logic        overflow,
    output logic        carry_out
);

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110
    } alu_op_e;

    logic [63:0] add2;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] b_arith;
    logic        is_sub;
    logic        is_arith;
    logic [63:0] sum_lo;
    logic [1:0]  sum_hi;
    logic [63:0] sum;
    logic        n_flag;
    logic        z_flag;
    logic        v_flag;
    logic        c_flag;
    logic        nq, zq, vq, cq;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        add2 = ALUsrc ? ALU_or_DT : ReadData2;

        unique case (forwardA)
            2'b01:   op_a = alu_result_mem;
            2'b10:   op_a = alu_result_wb;
            default: op_a = ReadData1;
        endcase

        unique case (forwardB)
            2'b01:   op_b = alu_result_mem;
            2'b10:   op_b = alu_result_wb;
            default: op_b = add2;
        endcase
    end

    // Split the adder at bit 63 so carry-in and carry-out of the MSB are both visible for V.
    always_comb begin
        is_sub   = (ALUop == OP_SUB);
        is_arith = (ALUop == OP_ADD) || is_sub;
        b_arith  = is_sub ? ~op_b : op_b;
        sum_lo   = {1'b0, op_a[62:0]} + {1'b0, b_arith[62:0]} + {63'd0, is_sub};
        sum_hi   = {1'b0, op_a[63]} + {1'b0, b_arith[63]} + {1'b0, sum_lo[63]};
        sum      = {sum_hi[0], sum_lo[62:0]};

        alu_result = 64'd0;
        case (ALUop)
            OP_PASS: alu_result = op_b;
            OP_ADD,
            OP_SUB:  alu_result = sum;
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            default: alu_result = 64'd0;
        endcase

        n_flag = alu_result[63];
        z_flag = (alu_result == 64'd0);
        c_flag = is_arith & sum_hi[1];
        v_flag = is_arith & (sum_lo[63] ^ sum_hi[1]);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nq <= 1'b0;
            zq <= 1'b0;
            vq <= 1'b0;
            cq <= 1'b0;
        end else if (update) begin
            nq <= n_flag;
            zq <= z_flag;
            vq <= v_flag;
            cq <= c_flag;
        end
    end

    // The bypass uses the live ALU zero, never the zero output, so no loop forms.
    assign zero      = cbz_id ? z_flag : zq;
    assign negative  = nq;
    assign overflow  = vq;
    assign carry_out = cq;

    assign new_PC2 = PC + {BR_to_shift[61:0], 2'b00};

endmodule

// File: tb/tb_data_ex_unit.sv
// Directed self-checking bench for data_ex_unit: ALU ops, forwarding, flag
// registers, CBZ zero bypass, asynchronous reset and branch target.
module tb_data_ex_unit;

    logic        clk;
    logic        reset;
    logic [63:0] ReadData1, ReadData2, PC, ALU_or_DT, BR_to_shift;
    logic [63:0] alu_result_mem, alu_result_wb;
    logic [2:0]  ALUop;
    logic [1:0]  forwardA, forwardB;
    logic        ALUsrc, update, cbz_id;
    logic [63:0] alu_result, new_PC2;
    logic        negative, zero, overflow, carry_out;

    int n_checks = 0;
    int n_pass   = 0;

    data_ex_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ReadData1      (ReadData1),
        .ReadData2      (ReadData2),
        .PC             (PC),
        .ALU_or_DT      (ALU_or_DT),
        .BR_to_shift    (BR_to_shift),
        .alu_result_mem (alu_result_mem),
        .alu_result_wb  (alu_result_wb),
        .ALUop          (ALUop),
        .forwardA       (forwardA),
        .forwardB       (forwardB),
        .ALUsrc         (ALUsrc),
        .update         (update),
        .cbz_id         (cbz_id),
        .alu_result     (alu_result),
        .new_PC2        (new_PC2),
        .negative       (negative),
        .zero           (zero),
        .overflow       (overflow),
        .carry_out      (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Flags packed as {N, Z, V, C}
    function automatic logic [63:0] flags();
        return {60'd0, negative, zero, overflow, carry_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        ReadData1 = '0; ReadData2 = '0; PC = '0; ALU_or_DT = '0; BR_to_shift = '0;
        alu_result_mem = '0; alu_result_wb = '0;
        ALUop = 3'b000; forwardA = 2'b00; forwardB = 2'b00;
        ALUsrc = 1'b0; update = 1'b0; cbz_id = 1'b0;
        #2;
        check("reset_flags", flags(), 64'h0);
        tick();
        check("reset_flags_after_edge", flags(), 64'h0);
        reset = 1'b1;

        // Add via register operand, no flag update
        ReadData1 = 64'h2AA; ReadData2 = 64'h155; ALUop = 3'b010; BR_to_shift = 64'd2;
        #1;
        check("add_reg", alu_result, 64'h3FF);
        check("br_target_2", new_PC2, 64'h8);
        tick(); tick();
        check("add_reg_flags_hold", flags(), 64'h0);

        // Add via immediate with update
        ALU_or_DT = 64'd1; ALUsrc = 1'b1; update = 1'b1; BR_to_shift = 64'h80;
        #1;
        check("add_imm", alu_result, 64'h2AB);
        check("br_target_80", new_PC2, 64'h200);
        tick();
        check("add_imm_flags", flags(), 64'h0);

        // Negative result, held off until update
        update = 1'b0; ReadData1 = 64'hFFFF_FFFF_FFFF_FAAA;
        #1;
        check("neg_result", alu_result, 64'hFFFF_FFFF_FFFF_FAAB);
        tick();
        check("neg_no_update", flags(), 64'h0);
        update = 1'b1;
        tick();
        check("neg_update", flags(), 64'b1000);

        // 5 - 5: Z=1, C=1 (no borrow)
        ReadData1 = 64'd5; ALU_or_DT = 64'd5; ALUop = 3'b011;
        #1;
        check("sub_zero", alu_result, 64'h0);
        tick();
        check("sub_zero_flags", flags(), 64'b0101);

        // 3 - 5: borrow, negative
        ReadData1 = 64'd3;
        #1;
        check("sub_borrow", alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        check("sub_borrow_flags", flags(), 64'b1000);

        // Signed overflow on add
        ReadData1 = 64'h7FFF_FFFF_FFFF_FFFF; ALU_or_DT = 64'd1; ALUop = 3'b010;
        #1;
        check("add_ovf", alu_result, 64'h8000_0000_0000_0000);
        tick();
        check("add_ovf_flags", flags(), 64'b1010);

        // Unsigned carry out on add
        ReadData1 = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("add_carry", alu_result, 64'h0);
        tick();
        check("add_carry_flags", flags(), 64'b0101);
        update = 1'b0;

        // Forwarding
        forwardA = 2'b01; alu_result_mem = 64'd10;
        forwardB = 2'b10; alu_result_wb = 64'd3; ALUop = 3'b011;
        #1;
        check("fwd_mem_wb_sub", alu_result, 64'd7);
        forwardB = 2'b11; ALU_or_DT = 64'd4;
        #1;
        check("fwdB_11_add2", alu_result, 64'd6);
        forwardA = 2'b10; forwardB = 2'b01;
        #1;
        check("fwd_wb_mem_sub", alu_result, 64'hFFFF_FFFF_FFFF_FFF9);
        forwardA = 2'b11; ReadData1 = 64'd20; forwardB = 2'b00; ALUsrc = 1'b0; ReadData2 = 64'd8;
        #1;
        check("fwdA_11_rd1", alu_result, 64'd12);
        forwardA = 2'b00;

        // Logic ops and undefined ops
        ReadData1 = 64'hF0F0; ReadData2 = 64'hFF00;
        ALUop = 3'b100; #1; check("and", alu_result, 64'hF000);
        ALUop = 3'b101; #1; check("or",  alu_result, 64'hFFF0);
        ALUop = 3'b110; #1; check("xor", alu_result, 64'h0FF0);
        ALUop = 3'b000; #1; check("pass", alu_result, 64'hFF00);
        ALUop = 3'b001; #1; check("op001", alu_result, 64'h0);
        ALUop = 3'b111; #1; check("op111", alu_result, 64'h0);

        // Branch target: upper bits of offset shifted out, wraparound
        PC = 64'hFFFF_FFFF_FFFF_FFF0; BR_to_shift = 64'hC000_0000_0000_0005;
        #1;
        check("br_wrap", new_PC2, 64'h4);

        // Clear zq, then CBZ bypass
        ALUop = 3'b000; ReadData2 = 64'd9; update = 1'b1;
        tick();
        check("zq_cleared", flags(), 64'b0000);
        update = 1'b0; ReadData2 = 64'd0; cbz_id = 1'b1;
        #1;
        check("cbz_bypass_z1", {63'd0, zero}, 64'd1);
        ReadData2 = 64'd1;
        #1;
        check("cbz_bypass_z0", {63'd0, zero}, 64'd0);
        ReadData2 = 64'd0; cbz_id = 1'b0;
        #1;
        check("cbz_off_uses_zq", {63'd0, zero}, 64'd0);

        // Set flags, then asynchronous reset mid-cycle
        ReadData1 = 64'h7FFF_FFFF_FFFF_FFFF; ALU_or_DT = 64'd1; ALUsrc = 1'b1;
        ALUop = 3'b010; update = 1'b1;
        tick();
        check("pre_reset_flags", flags(), 64'b1010);
        #2 reset = 1'b0;
        #1;
        check("async_reset_flags", flags(), 64'h0);
        tick();
        check("reset_holds_with_update", flags(), 64'h0);
        cbz_id = 1'b1; ReadData2 = 64'd0; ALUsrc = 1'b0; ALUop = 3'b000;
        #1;
        check("reset_cbz_zero", {63'd0, zero}, 64'd1);
        cbz_id = 1'b0; update = 1'b0;
        #1 reset = 1'b1;
        tick();
        check("post_reset_hold", flags(), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
